dma_2d_write_master: RTL and testbench

DMA_2D_WRITE_MASTER -- requirements
Module: dma_2d_write_master

---
 rtl/dma_2d_write_master.sv | 182 ++++++++++++++++++
 tb/tb_dma_2d_write_master.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_2d_write_master.sv
// 2D write DMA: streams width x height rows from an FWFT FIFO into memory as AXI4 INCR bursts,
// one burst outstanding. Define DMA_WR_4K_SPLIT_EN to stop bursts at 4 KB boundaries.
module dma_2d_write_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_BURST_LEN  = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            i_start,
  input  logic [31:0]                     i_dst_addr,
  input  logic [31:0]                     i_img_width,
  input  logic [31:0]                     i_img_height,
  input  logic [31:0]                     i_img_stride,
  output logic                            o_write_done,
  output logic                            o_error,
  output logic                            o_fifo_pop,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_fifo_data,
  input  logic                            i_fifo_empty,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] height_q, height_d;
  logic [31:0] stride_q, stride_d;
  logic [31:0] row_q, row_d;
  logic [31:0] row_addr_q, row_addr_d;
  logic [31:0] addr_q, addr_d;
  logic [29:0] row_words_q, row_words_d;
  logic [29:0] rem_q, rem_d;
  logic [8:0]  beats_q, beats_d;
  logic [7:0]  awlen_q, awlen_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        error_q, error_d;

  logic [31:0] beats_calc;
  logic [29:0] rem_next;
  logic        w_valid, w_hs, w_last;

  always_comb begin
    beats_calc = (32'(rem_q) < 32'(C_M_AXI_BURST_LEN)) ? 32'(rem_q) : 32'(C_M_AXI_BURST_LEN);
`ifdef DMA_WR_4K_SPLIT_EN
    // words left before the next 4 KB boundary; never 0 because addr is word aligned
    if (((32'h0000_1000 - {20'd0, addr_q[11:0]}) >> 2) < beats_calc)
      beats_calc = (32'h0000_1000 - {20'd0, addr_q[11:0]}) >> 2;
`endif
  end

  assign w_valid = (state_q == S_W) && !i_fifo_empty;
  assign w_hs    = w_valid && M_AXI_WREADY;
  assign w_last  = (state_q == S_W) && (beat_cnt_q == awlen_q);

  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    stride_d    = stride_q;
    row_d       = row_q;
    row_addr_d  = row_addr_q;
    addr_d      = addr_q;
    row_words_d = row_words_q;
    rem_d       = rem_q;
    beats_d     = beats_q;
    awlen_d     = awlen_q;
    beat_cnt_d  = beat_cnt_q;
    awaddr_d    = awaddr_q;
    error_d     = error_q;
    rem_next    = rem_q - 30'(beats_q);
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          height_d    = i_img_height;
          stride_d    = i_img_stride;
          row_words_d = i_img_width[31:2];
          rem_d       = i_img_width[31:2];
          row_d       = '0;
          row_addr_d  = i_dst_addr;
          addr_d      = i_dst_addr;
          error_d     = 1'b0;
          state_d     = (i_img_width < 32'd4 || i_img_height == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        beats_d    = 9'(beats_calc);
        awlen_d    = 8'(beats_calc - 32'd1);
        awaddr_d   = addr_q;
        beat_cnt_d = '0;
        state_d    = S_AW;
      end
      S_AW: begin
        if (M_AXI_AWREADY) state_d = S_W;
      end
      S_W: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (w_last) state_d = S_B;
        end
      end
      S_B: begin
        if (M_AXI_BVALID) begin
          error_d = error_q | (M_AXI_BRESP != 2'b00);
          addr_d  = addr_q + 32'({beats_q, 2'b00});
          if (rem_next != '0) begin
            rem_d   = rem_next;
            state_d = S_CALC;
          end else begin
            // row finished: restart from the next row start, not from the running address
            row_d      = row_q + 32'd1;
            row_addr_d = row_addr_q + stride_q;
            addr_d     = row_addr_q + stride_q;
            rem_d      = row_words_q;
            state_d    = ((row_q + 32'd1) < height_q) ? S_CALC : S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      height_q    <= '0;
      stride_q    <= '0;
      row_q       <= '0;
      row_addr_q  <= '0;
      addr_q      <= '0;
      row_words_q <= '0;
      rem_q       <= '0;
      beats_q     <= '0;
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      awaddr_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      row_q       <= row_d;
      row_addr_q  <= row_addr_d;
      addr_q      <= addr_d;
      row_words_q <= row_words_d;
      rem_q       <= rem_d;
      beats_q     <= beats_d;
      awlen_q     <= awlen_d;
      beat_cnt_q  <= beat_cnt_d;
      awaddr_q    <= awaddr_d;
      error_q     <= error_d;
    end
  end

  assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(awaddr_q);
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = (state_q == S_AW);
  assign M_AXI_WDATA   = i_fifo_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_last;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_BREADY  = (state_q == S_B);
  assign o_fifo_pop    = w_hs;
  assign o_write_done  = (state_q == S_DONE);
  assign o_error       = error_q;

endmodule

// File: tb/tb_dma_2d_write_master.sv
// Randomized bench for dma_2d_write_master: burst list and data order come from a row/byte model.
module tb_dma_2d_write_master;

  localparam int unsigned BL = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_dst_addr, i_img_width, i_img_height, i_img_stride;
  logic        o_write_done, o_error, o_fifo_pop;
  logic [31:0] i_fifo_data;
  logic        i_fifo_empty;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  always #5 clk = ~clk;

  dma_2d_write_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_BURST_LEN (BL)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .i_start      (i_start),
    .i_dst_addr   (i_dst_addr),
    .i_img_width  (i_img_width),
    .i_img_height (i_img_height),
    .i_img_stride (i_img_stride),
    .o_write_done (o_write_done),
    .o_error      (o_error),
    .o_fifo_pop   (o_fifo_pop),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .M_AXI_AWADDR (AWADDR),
    .M_AXI_AWLEN  (AWLEN),
    .M_AXI_AWSIZE (AWSIZE),
    .M_AXI_AWBURST(AWBURST),
    .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA  (WDATA),
    .M_AXI_WSTRB  (WSTRB),
    .M_AXI_WLAST  (WLAST),
    .M_AXI_WVALID (WVALID),
    .M_AXI_WREADY (WREADY),
    .M_AXI_BRESP  (BRESP),
    .M_AXI_BVALID (BVALID),
    .M_AXI_BREADY (BREADY)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  burst_t      exp_bursts[$];
  logic [31:0] fifo[$];
  logic [31:0] exp_data[$];
  int unsigned wlast_pos[$];

  int unsigned fifo_mode = 0, rdy_mode = 0, cyc = 0;
  int          err_burst = -1;
  int unsigned b_index = 0, b_owed = 0;
  logic        pop_seen = 1'b0, b_hs_seen = 1'b0;
  logic        burst_open = 1'b0;
  int unsigned beat = 0, cur_len = 0;
  int unsigned job_aw = 0, job_beats = 0, job_pops = 0, job_awv = 0, done_cnt = 0;
  logic        prev_aw_wait = 1'b0, prev_w_wait = 1'b0;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [7:0]  prev_awlen;
  logic        prev_err = 1'b0;
  logic        aw_hs, w_hs, b_hs;
  burst_t      mon_b;
  logic [31:0] mon_d;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: each row is cut into bursts of at most BL words (and at 4 KB lines when split is on).
  task automatic build_model(input logic [31:0] dst, input logic [31:0] w,
                             input logic [31:0] h, input logic [31:0] s);
    exp_bursts.delete();
    for (int unsigned r = 0; r < h; r++) begin
      logic [31:0] a;
      int unsigned words;
      a = dst + r * s;
      words = w / 4;
      while (words > 0) begin
        int unsigned n;
        n = (words < BL) ? words : BL;
`ifdef DMA_WR_4K_SPLIT_EN
        begin
          int unsigned room;
          room = (4096 - (a % 4096)) / 4;
          if (room < n) n = room;
        end
`endif
        exp_bursts.push_back('{addr: a, len: 8'(n - 1)});
        a = a + 4 * n;
        words = words - n;
      end
    end
  endtask

  // Upstream FIFO, AW/W readiness and B responder, all driven just after the rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
    pop_seen = 1'b0;
    if (fifo_mode == 0) begin
      while (fifo.size() < 4) begin
        logic [31:0] wd;
        wd = $urandom;
        fifo.push_back(wd);
        exp_data.push_back(wd);
      end
    end else if ((cyc % 2) == 0 && fifo.size() < 8) begin
      logic [31:0] wd;
      wd = $urandom;
      fifo.push_back(wd);
      exp_data.push_back(wd);
    end
    i_fifo_empty = (fifo.size() == 0);
    i_fifo_data  = (fifo.size() > 0) ? fifo[0] : '0;
    AWREADY = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    WREADY  = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (b_hs_seen) begin
      BVALID    = 1'b0;
      b_hs_seen = 1'b0;
    end
    if (b_owed > 0 && !BVALID && (rdy_mode == 0 || $urandom_range(0, 1) == 1)) begin
      BVALID = 1'b1;
      BRESP  = (int'(b_index) == err_burst) ? 2'b10 : 2'b00;
      b_index++;
      b_owed--;
    end
  end

  // Protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      if (prev_aw_wait) begin
        check_eq("aw_valid_hold", 32'(AWVALID), 32'd1);
        check_eq("aw_addr_hold", AWADDR, prev_awaddr);
        check_eq("aw_len_hold", 32'(AWLEN), 32'(prev_awlen));
      end
      if (prev_w_wait) begin
        check_eq("w_valid_hold", 32'(WVALID), 32'd1);
        check_eq("w_data_hold", WDATA, prev_wdata);
      end
      prev_aw_wait = AWVALID && !AWREADY;
      prev_awaddr  = AWADDR;
      prev_awlen   = AWLEN;
      prev_w_wait  = WVALID && !WREADY;
      prev_wdata   = WDATA;
      if (WVALID) check_eq("wvalid_needs_data", 32'(i_fifo_empty), 32'd0);
      if (o_fifo_pop || w_hs) check_eq("pop_eq_w_handshake", 32'(o_fifo_pop), 32'(w_hs));
      if (aw_hs) begin
        job_aw++;
        check_eq("aw_single_outstanding", 32'(burst_open), 32'd0);
        check_eq("aw_size_burst", {27'd0, AWSIZE, AWBURST}, 32'h0000_0009);
        check_eq("aw_expected", 32'(exp_bursts.size() > 0), 32'd1);
        cur_len = 0;
        if (exp_bursts.size() > 0) begin
          mon_b = exp_bursts.pop_front();
          check_eq("awaddr", AWADDR, mon_b.addr);
          check_eq("awlen", 32'(AWLEN), 32'(mon_b.len));
          cur_len = 32'(mon_b.len);
        end
        burst_open = 1'b1;
        beat = 0;
      end
      if (w_hs) begin
        job_beats++;
        check_eq("w_inside_burst", 32'(burst_open), 32'd1);
        check_eq("wstrb", 32'(WSTRB), 32'h0000_000F);
        if (exp_data.size() > 0) begin
          mon_d = exp_data.pop_front();
          check_eq("wdata_order", WDATA, mon_d);
        end
        check_eq("wlast", 32'(WLAST), 32'(beat == cur_len));
        if (WLAST) wlast_pos.push_back(job_beats);
        if (beat == cur_len) begin
          burst_open = 1'b0;
          b_owed++;
        end
        beat++;
      end
      pop_seen  = o_fifo_pop;
      b_hs_seen = b_hs;
      if (o_fifo_pop) job_pops++;
      if (AWVALID) job_awv++;
      if (o_write_done) done_cnt++;
    end
  end

  task automatic check_idle_outputs();
    check_eq("rst_awvalid", 32'(AWVALID), 32'd0);
    check_eq("rst_wvalid", 32'(WVALID), 32'd0);
    check_eq("rst_wlast", 32'(WLAST), 32'd0);
    check_eq("rst_bready", 32'(BREADY), 32'd0);
    check_eq("rst_pop", 32'(o_fifo_pop), 32'd0);
    check_eq("rst_done", 32'(o_write_done), 32'd0);
    check_eq("rst_error", 32'(o_error), 32'd0);
    check_eq("rst_awaddr", AWADDR, 32'd0);
    check_eq("rst_awlen", 32'(AWLEN), 32'd0);
  endtask

  task automatic pulse_start(input logic [31:0] dst, input logic [31:0] w,
                             input logic [31:0] h, input logic [31:0] s);
    job_aw = 0; job_beats = 0; job_pops = 0; job_awv = 0; b_index = 0;
    wlast_pos.delete();
    @(posedge clk);
    #2;
    i_dst_addr = dst; i_img_width = w; i_img_height = h; i_img_stride = s;
    i_start = 1'b1;
    @(posedge clk);
    #2;
    i_start = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] dst, input logic [31:0] w, input logic [31:0] h,
                         input logic [31:0] s, input int unsigned fm, input int unsigned rm,
                         input int eb);
    int unsigned nb, waited, done_base, words_total;
    logic        exp_err;
    build_model(dst, w, h, s);
    nb          = exp_bursts.size();
    exp_err     = (eb >= 0) && (eb < int'(nb));
    words_total = h * (w / 4);
    fifo_mode = fm; rdy_mode = rm; err_burst = eb;
    done_base = done_cnt;
    pulse_start(dst, w, h, s);
    if (prev_err) check_eq("error_cleared_on_start", 32'(o_error), 32'd0);
    waited = 0;
    while (done_cnt == done_base && waited < 4000) begin
      @(posedge clk);
      waited++;
    end
    check_eq("done_seen", done_cnt - done_base, 32'd1);
    check_eq("error_at_done", 32'(o_error), 32'(exp_err));
    check_eq("bursts_left", exp_bursts.size(), 32'd0);
    check_eq("beats_total", job_beats, words_total);
    check_eq("pops_total", job_pops, words_total);
    repeat (3) @(posedge clk);
    check_eq("done_single_pulse", done_cnt - done_base, 32'd1);
    prev_err = exp_err;
  endtask

  initial begin
    int unsigned waited;
    rst_n = 1'b0; i_start = 1'b0;
    i_dst_addr = '0; i_img_width = '0; i_img_height = '0; i_img_stride = '0;
    i_fifo_data = '0; i_fifo_empty = 1'b1;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs();
    @(negedge clk);
    #3 rst_n = 1'b1;

    run_job(32'h0000_1000, 32'd64, 32'd2, 32'd256, 0, 0, -1);
    check_eq("r41_aw_count", job_aw, 32'd2);
    check_eq("r41_pops", job_pops, 32'd32);

    run_job(32'h0000_1000, 32'd72, 32'd1, 32'd0, 0, 0, -1);
    check_eq("r42_aw_count", job_aw, 32'd2);
    check_eq("r42_wlast_count", wlast_pos.size(), 32'd2);
    if (wlast_pos.size() == 2) begin
      check_eq("r42_wlast_first", wlast_pos[0], 32'd16);
      check_eq("r42_wlast_second", wlast_pos[1], 32'd18);
    end

    run_job(32'h0000_0FF8, 32'd64, 32'd1, 32'd64, 0, 0, -1);
`ifdef DMA_WR_4K_SPLIT_EN
    check_eq("r44_aw_count", job_aw, 32'd2);
`else
    check_eq("r44_aw_count", job_aw, 32'd1);
`endif

    run_job(32'h0000_3000, 32'd80, 32'd2, 32'd128, 1, 1, 1);
    run_job(32'h0000_4000, 32'd64, 32'd0, 32'd64, 0, 0, -1);
    check_eq("h0_no_awvalid", job_awv, 32'd0);

    run_job(32'hFFFF_FFF0, 32'd64, 32'd2, 32'd256, 1, 1, -1);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] dst, w, h, s;
      dst = {$urandom_range(0, 32'h0000_3FFF), 2'b00};
      w   = 4 * $urandom_range(1, 40);
      h   = $urandom_range(1, 3);
      s   = w + 4 * $urandom_range(0, 300);
      run_job(dst, w, h, s, $urandom_range(0, 1), $urandom_range(0, 1),
              int'($urandom_range(0, 4)) - 1);
    end

    build_model(32'h0000_2000, 32'd160, 32'd3, 32'd512);
    fifo_mode = 1; rdy_mode = 1; err_burst = -1;
    pulse_start(32'h0000_2000, 32'd160, 32'd3, 32'd512);
    waited = 0;
    while (job_beats < 4 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    check_eq("midw_reached", 32'(job_beats >= 4), 32'd1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs();
    pop_seen = 1'b0; b_hs_seen = 1'b0; BVALID = 1'b0; b_owed = 0;
    exp_bursts.delete();
    burst_open = 1'b0; prev_aw_wait = 1'b0; prev_w_wait = 1'b0;
    exp_data = fifo;
    prev_err = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    run_job(32'h0000_5000, 32'd96, 32'd2, 32'd128, 1, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
